// File: rtl/aes_shift_mix_stage.sv
`default_nettype none
// ============================================================================
// aes_shift_mix_stage : registered ShiftRows + MixColumns AES round stage
//                       with a 2-entry skid buffer and completed-block count
// Revision 1.0
// ============================================================================
module aes_shift_mix_stage #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_state,
    input  logic             in_last,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_state,
    output logic             out_last,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] blk_count
);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        mix_col[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        mix_col[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        mix_col[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        mix_col[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    endfunction

    logic [127:0]     w_sr;
    logic [127:0]     w_mix;
    logic [127:0]     w_xf;
    logic             w_accept;
    logic             w_emit;

    logic             r_main_valid;
    logic [127:0]     r_main_state;
    logic             r_main_last;
    logic [TAG_W-1:0] r_main_tag;
    logic             r_skid_valid;
    logic [127:0]     r_skid_state;
    logic             r_skid_last;
    logic [TAG_W-1:0] r_skid_tag;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_blk_count;

    // Byte (row r, column c) sits at in_state[127-8*(4c+r) -: 8].
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_sr[127-8*(4*c+r) -: 8] = in_state[127-8*(4*((c+r)%4)+r) -: 8];
        end
        assign w_mix[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
    end

    assign w_xf     = in_last ? w_sr : w_mix;
    assign w_accept = in_valid && r_in_ready;
    assign w_emit   = r_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_state <= '0;
            r_main_last  <= 1'b0;
            r_main_tag   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_state <= '0;
            r_skid_last  <= 1'b0;
            r_skid_tag   <= '0;
            r_in_ready   <= 1'b1;
            r_blk_count  <= '0;
        end else begin
            if (w_emit) begin
                r_blk_count <= r_blk_count + 1'b1;
                if (r_skid_valid) begin
                    // in_ready is low while the skid is full, so no accept competes here
                    r_main_state <= r_skid_state;
                    r_main_last  <= r_skid_last;
                    r_main_tag   <= r_skid_tag;
                    r_skid_valid <= 1'b0;
                    r_in_ready   <= 1'b1;
                end else if (w_accept) begin
                    r_main_state <= w_xf;
                    r_main_last  <= in_last;
                    r_main_tag   <= in_tag;
                end else begin
                    r_main_valid <= 1'b0;
                end
            end else if (w_accept) begin
                if (!r_main_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_state <= w_xf;
                    r_main_last  <= in_last;
                    r_main_tag   <= in_tag;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_state <= w_xf;
                    r_skid_last  <= in_last;
                    r_skid_tag   <= in_tag;
                    r_in_ready   <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_state = r_main_state;
    assign out_last  = r_main_last;
    assign out_tag   = r_main_tag;
    assign blk_count = r_blk_count;

endmodule
`default_nettype wire

// File: tb/tb_aes_shift_mix_stage.sv
`default_nettype none
// ============================================================================
// tb_aes_shift_mix_stage : scoreboard bench for the ShiftRows/MixColumns stage
// Revision 1.0
// ============================================================================
module tb_aes_shift_mix_stage;

    typedef struct packed {
        logic [127:0] st;
        logic         last;
        logic [3:0]   tag;
    } blk_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_state = '0;
    logic         in_last = 1'b0;
    logic [3:0]   in_tag = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_state;
    logic         out_last;
    logic [3:0]   out_tag;
    logic [15:0]  blk_count;

    int           n_cmp = 0;
    int           n_err = 0;
    int           n_acc = 0;
    int           n_emit = 0;
    logic [15:0]  exp_cnt = '0;
    logic         rand_rdy = 1'b0;
    blk_t         q[$];

    aes_shift_mix_stage #(.TAG_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .in_last(in_last), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_last(out_last), .out_tag(out_tag), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [132:0] act, input logic [132:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic last);
        logic [7:0]   a[4][4];
        logic [7:0]   b[4][4];
        logic [7:0]   cf[4];
        logic [7:0]   acc;
        logic [127:0] res;
        cf[0] = 8'd2; cf[1] = 8'd3; cf[2] = 8'd1; cf[3] = 8'd1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                a[r][c] = s[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[r][c] = a[r][(c+r)%4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                if (last) begin
                    acc = b[r][c];
                end else begin
                    acc = '0;
                    for (int k = 0; k < 4; k++)
                        acc = acc ^ gmul(b[k][c], cf[(k-r+4)%4]);
                end
                res[127-8*(4*c+r) -: 8] = acc;
            end
        return res;
    endfunction

    task automatic send(input logic [127:0] s, input logic last, input logic [3:0] tag,
                        input logic [127:0] exp_st);
        logic ok;
        int   waited;
        in_valid = 1'b1; in_state = s; in_last = last; in_tag = tag;
        q.push_back('{st: exp_st, last: last, tag: tag});
        waited = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 2000) begin
                n_cmp++; n_err++;
                $display("FAIL send_timeout: in_ready stuck low, tag %0d", tag);
                break;
            end
        end
    endtask

    task automatic send_m(input logic [127:0] s, input logic last, input logic [3:0] tag);
        send(s, last, tag, model(s, last));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            in_state = {$urandom, $urandom, $urandom, $urandom};
            in_last  = 1'($urandom);
            in_tag   = 4'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int waited = 0;
        in_valid = 1'b0;
        while (q.size() != 0 && waited < 5000) begin
            @(posedge clk);
            #1;
            waited++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d blocks outstanding, expected 0", q.size());
        end
        idle(2);
    endtask

    // Monitor: occupancy model predicts in_ready/out_valid; pops scoreboard on each emit.
    initial begin
        blk_t   e;
        logic   held_v = 1'b0;
        blk_t   held;
        int     occ;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                n_acc = 0; n_emit = 0; exp_cnt = '0; held_v = 1'b0;
            end else begin
                occ = n_acc - n_emit;
                check("in_ready_occ", 133'(in_ready), 133'(occ < 2));
                check("out_valid_occ", 133'(out_valid), 133'(occ > 0));
                check("blk_count", 133'(blk_count), 133'(exp_cnt));
                if (held_v && out_valid)
                    check("stall_stable", {out_state, out_last, out_tag}, held);
                held_v = out_valid && !out_ready;
                held   = '{st: out_state, last: out_last, tag: out_tag};
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_output: got %h, expected none", out_state);
                    end else begin
                        e = q.pop_front();
                        check("output_block", {out_state, out_last, out_tag}, e);
                    end
                    n_emit++;
                    exp_cnt = exp_cnt + 16'd1;
                end
                if (in_valid && in_ready) n_acc++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] s;
        logic [15:0]  base;
        logic         l;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out", {out_state, out_last, out_tag}, 133'd0);
        check("reset_flags", {130'd0, out_valid, in_ready, 1'b0}, {130'd0, 1'b0, 1'b1, 1'b0});
        @(posedge clk); #1;

        // FIPS-197 round 1 vectors and hand-derived equal-column vectors
        out_ready = 1'b1;
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'd1, 128'h046681e5e0cb199a48f8d37a2806264c);
        in_valid = 1'b0;
        @(negedge clk);
        check("fips_latency", {out_valid, out_state, out_tag}, {1'b1, 128'h046681e5e0cb199a48f8d37a2806264c, 4'd1});
        @(posedge clk); #1;
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 4'd10, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        send({4{32'hdb135345}}, 1'b0, 4'd2, {4{32'h8e4da1bc}});
        send({4{32'hf20a225c}}, 1'b0, 4'd3, {4{32'h9fdc589d}});
        send({4{32'hc6c6c6c6}}, 1'b0, 4'd4, {4{32'hc6c6c6c6}});
        send(128'h0, 1'b0, 4'd5, 128'h0);
        send(128'h000102030405060708090a0b0c0d0e0f, 1'b1, 4'd14, 128'h00050a0f04090e03080d02070c01060b);
        drain();

        // Back-to-back stream at full throughput
        base = exp_cnt;
        for (int k = 0; k < 64; k++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            send_m(s, 1'b0, 4'(k));
        end
        drain();
        check("b2b_count", 133'(blk_count), 133'(base + 16'd64));

        // Backpressure: A in main, B in skid
        out_ready = 1'b0;
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 4'd7, 128'h046681e5e0cb199a48f8d37a2806264c);
        send_m(128'h00112233445566778899aabbccddeeff, 1'b1, 4'd8);
        idle(1);
        @(negedge clk);
        check("bp_in_ready", 133'(in_ready), 133'd0);
        check("bp_head", {out_valid, out_state, out_tag}, {1'b1, 128'h046681e5e0cb199a48f8d37a2806264c, 4'd7});
        idle(3);
        out_ready = 1'b1;
        drain();

        // Random valid/ready traffic
        rand_rdy = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(1, 0) == 1) idle(1);
            s = {$urandom, $urandom, $urandom, $urandom};
            l = 1'($urandom);
            send_m(s, l, 4'($urandom));
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with both entries full
        out_ready = 1'b0;
        send_m(128'hfedcba98765432100123456789abcdef, 1'b0, 4'd9);
        send_m(128'h0f0e0d0c0b0a09080706050403020100, 1'b0, 4'd6);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid", {out_valid, in_ready, blk_count}, {1'b1 ^ 1'b1, 1'b1, 16'd0});
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, 4'd15, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        drain();
        check("post_rst_count", 133'(blk_count), 133'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
